// File: rtl/data_memory_responder.sv
// Single-port 64-byte word responder: accepts one load/store, waits LATENCY
// cycles, commits, then holds a response until the initiator consumes it.
module data_memory_responder #(
  parameter int unsigned LATENCY      = 2,
  parameter bit          STRICT_ALIGN = 1'b1
) (
  input  logic        system_clock,
  input  logic        system_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [5:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a presented response holds
  // its payload stable until that transfer edge.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  mem_q [64];

  logic        accept;
  logic        commit;
  logic        c_wr;
  logic [5:0]  c_addr;
  logic [31:0] c_wdata;
  logic        c_mis;
  logic [5:0]  a0, a1, a2, a3;
  logic [31:0] c_load;

  assign req_ready   = system_reset_n && (state_q == S_IDLE);
  assign accept      = req_valid && req_ready;
  assign resp_valid  = valid_q;
  assign resp_rdata  = rdata_q;
  assign resp_error  = err_q;
  assign dbg_state_o = state_q;

  // With zero latency the commit happens on the accept edge itself, so the
  // request is taken straight from the inputs; otherwise from the latches.
  assign c_wr    = (state_q == S_IDLE) ? req_write : wr_q;
  assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign c_mis   = STRICT_ALIGN && (c_addr[1:0] != 2'b00);

  assign a0     = c_addr;
  assign a1     = c_addr + 6'd1;
  assign a2     = c_addr + 6'd2;
  assign a3     = c_addr + 6'd3;
  assign c_load = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT;
          if (LAT == 4'd0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        // resp_valid is registered one cycle behind RESP entry, so the
        // response appears LATENCY+1 edges after acceptance.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      err_d = c_mis;
      if (c_mis)     rdata_d = 32'd0;
      else if (c_wr) rdata_d = c_wdata;
      else           rdata_d = c_load;
    end
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 32'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; writes are blocked while reset is low.
  always_ff @(posedge system_clock) begin
    if (system_reset_n && commit && c_wr && !c_mis) begin
      mem_q[a0] <= c_wdata[31:24];
      mem_q[a1] <= c_wdata[23:16];
      mem_q[a2] <= c_wdata[15:8];
      mem_q[a3] <= c_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (LATENCY 2/0/3, strict and
// relaxed alignment) checked against a byte-array reference model.
module tb_data_memory_responder;

  logic        clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [5:0]  req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_error [3];
  logic [1:0]  dbg_state  [3];

  logic [7:0]  mdl [3][64];
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .LATENCY      (g == 0 ? 2 : (g == 1 ? 0 : 3)),
      .STRICT_ALIGN (g == 1 ? 1'b0 : 1'b1)
    ) dut (
      .system_clock   (clk),
      .system_reset_n (rst_n[g]),
      .req_valid      (req_valid[g]),
      .req_ready      (req_ready[g]),
      .req_write      (req_write[g]),
      .req_addr       (req_addr[g]),
      .req_wdata      (req_wdata[g]),
      .resp_valid     (resp_valid[g]),
      .resp_ready     (resp_ready[g]),
      .resp_rdata     (resp_rdata[g]),
      .resp_error     (resp_error[g]),
      .dbg_state_o    (dbg_state[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic bit strict_of(input int d);
    return (d != 1);
  endfunction

  function automatic logic [5:0] wrap(input logic [5:0] a, input int i);
    return 6'((int'(a) + i) % 64);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid[d]}, 32'd0);
    chk("rst_resp_rdata", resp_rdata[d], 32'd0);
    chk("rst_resp_error", {31'd0, resp_error[d]}, 32'd0);
  endtask

  // One full transaction: accept, count edges to the response, hold it for
  // 'hold' cycles with resp_ready low, then consume it.
  task automatic run_txn(input int d, input bit wr, input logic [5:0] addr,
                         input logic [31:0] wd, input int hold);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          edges;
    exp_err = strict_of(d) && (addr[1:0] != 2'b00);
    if (exp_err) begin
      exp_rd = 32'd0;
    end else if (wr) begin
      exp_rd = wd;
      for (int i = 0; i < 4; i++) mdl[d][wrap(addr, i)] = wd[31-8*i -: 8];
    end else begin
      exp_rd = {mdl[d][wrap(addr, 0)], mdl[d][wrap(addr, 1)],
                mdl[d][wrap(addr, 2)], mdl[d][wrap(addr, 3)]};
    end

    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    @(posedge clk);
    #1;
    // Scramble the request lines; the DUT must ignore them until IDLE.
    req_write[d] = 1'($urandom);
    req_addr[d]  = 6'($urandom);
    req_wdata[d] = $urandom;
    edges = 0;
    while (resp_valid[d] !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("resp_latency", edges, lat_of(d) + 1);
    chk("resp_rdata", resp_rdata[d], exp_rd);
    chk("resp_error", {31'd0, resp_error[d]}, {31'd0, exp_err});
    chk("req_ready_busy", {31'd0, req_ready[d]}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, resp_valid[d]}, 32'd1);
      chk("hold_rdata", resp_rdata[d], exp_rd);
      chk("hold_req_ready", {31'd0, req_ready[d]}, 32'd0);
    end
    @(negedge clk);
    resp_ready[d] = 1'b1;
    req_valid[d]  = 1'b0;
    @(posedge clk);
    #1;
    resp_ready[d] = 1'b0;
    chk("post_valid", {31'd0, resp_valid[d]}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready[d]}, 32'd1);
    chk("post_rdata_held", resp_rdata[d], exp_rd);
  endtask

  initial begin
    int d;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_addr[i]   = 6'd0;
      req_wdata[i]  = 32'd0;
      resp_ready[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Fill every array with known words so all later loads are predictable.
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 16; a++) run_txn(i, 1'b1, 6'(a * 4), $urandom, 0);

    // Randomized mixed traffic, including misaligned and wrapping accesses.
    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 2));
      run_txn(d, 1'($urandom), 6'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    // LATENCY=2 store then load of 0xDEADBEEF at 8.
    run_txn(0, 1'b1, 6'd8, 32'hDEADBEEF, 0);
    run_txn(0, 1'b0, 6'd8, 32'd0, 0);
    chk("mdl_bytes_8", {mdl[0][8], mdl[0][9], mdl[0][10], mdl[0][11]}, 32'hDEADBEEF);

    // LATENCY=0 load held unconsumed for 5 cycles.
    run_txn(1, 1'b0, 6'd12, 32'd0, 5);

    // Strict alignment rejects a misaligned store and leaves bytes intact.
    run_txn(0, 1'b1, 6'd5, 32'h11223344, 2);
    run_txn(0, 1'b0, 6'd4, 32'd0, 0);
    run_txn(0, 1'b0, 6'd8, 32'd0, 0);

    // Relaxed alignment store wrapping from 63 to 0.
    run_txn(1, 1'b1, 6'd62, 32'hA1B2C3D4, 0);
    run_txn(1, 1'b0, 6'd62, 32'd0, 0);
    run_txn(1, 1'b0, 6'd0, 32'd0, 1);
    chk("mdl_wrap", {mdl[1][62], mdl[1][63], mdl[1][0], mdl[1][1]}, 32'hA1B2C3D4);

    // Reset during WAIT aborts a LATENCY=3 store.
    run_txn(2, 1'b1, 6'd16, 32'h0BADF00D, 0);
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2]  = 6'd16;
    req_wdata[2] = 32'h55555555;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    chk("wait_state", {30'd0, dbg_state[2]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    check_reset_outputs(2);
    chk("rst_state", {30'd0, dbg_state[2]}, 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    run_txn(2, 1'b0, 6'd16, 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
